// File: rtl/uart_tx_arbiter_pkg.sv
// uart_tx_arbiter_pkg: shared UART state encodings, clocking constants and index helper.
package uart_pkg;
    typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT_DONE} stateT;
    localparam int CLK_FREQ  = 125_000_000;
    localparam int BAUD_RATE = 115_200;
    function automatic int nextIdx(input int idx, input int n);
        return (idx + 1 == n) ? 0 : idx + 1;
    endfunction
endpackage

// File: rtl/uart_tx_arbiter_if.sv
// uart_tx_arbiter_if: requester handshake plus uart_tx start/byte/busy/done bundle.
interface uart_tx_arbiter_if #(parameter int NREQ = 4);
    logic [NREQ-1:0]   iValid;
    logic [NREQ*8-1:0] iData;
    logic [NREQ-1:0]   iLast;
    logic [NREQ-1:0]   oAck;
    logic              oTxStart;
    logic [7:0]        oTxByte;
    logic              iTxBusy;
    logic              iTxDone;
    modport slave  (input iValid, iData, iLast, iTxBusy, iTxDone, output oAck, oTxStart, oTxByte);
    modport master (output iValid, iData, iLast, iTxBusy, iTxDone, input oAck, oTxStart, oTxByte);
endinterface

// File: rtl/uart_tx_arbiter_rr_pick.sv
// uart_tx_arbiter_rr_pick: combinational round-robin picker, first request at or above ptr with wrap.
module uart_tx_arbiter_rr_pick #(
    parameter  int NREQ  = 4,
    localparam int IDX_W = $clog2(NREQ)
) (
    input  logic [NREQ-1:0]  req,
    input  logic [IDX_W-1:0] ptr,
    output logic [NREQ-1:0]  grant,
    output logic [IDX_W-1:0] idx,
    output logic             any
);
    logic [IDX_W-1:0] k;
    always_comb begin
        k   = '0;
        idx = '0;
        any = 1'b0;
        // Scan from the farthest offset down so the nearest request to ptr wins.
        for (int i = NREQ - 1; i >= 0; i--) begin
            k = IDX_W'((int'(ptr) + i) % NREQ);
            if (req[k]) begin
                any = 1'b1;
                idx = k;
            end
        end
        grant = any ? (NREQ'(1) << idx) : '0;
    end
endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin share of one uart_tx among NREQ byte requesters, one byte in flight.
// Frame lock (hold the grant until iLast) is enabled by defining UART_TX_ARB_LOCK_EN.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter  int NREQ  = 4,
    localparam int IDX_W = $clog2(NREQ)
) (
    input  logic             iClk,
    input  logic             iRstN,
    uart_tx_arbiter_if.slave bus,
    output logic             oBusy,
    output logic [IDX_W-1:0] oOwner
);
    stateT            state, stateNext;
    logic [IDX_W-1:0] ptr, winner;
    logic [NREQ-1:0]  eligible, grant;
    logic             any, go;
`ifdef UART_TX_ARB_LOCK_EN
    logic             locked;
    assign eligible = locked ? (bus.iValid & (NREQ'(1) << oOwner)) : bus.iValid;
`else
    assign eligible = bus.iValid;
`endif
    uart_tx_arbiter_rr_pick #(.NREQ(NREQ)) pick (
        .req  (eligible),
        .ptr  (ptr),
        .grant(grant),
        .idx  (winner),
        .any  (any)
    );
    // Gated by iRstN so no ack can leak out while reset is held.
    assign go = iRstN && state == S_IDLE && any && !bus.iTxBusy;
    always_comb begin
        stateNext    = state == S_IDLE  ? (go ? S_START : S_IDLE) :
                       state == S_START ? S_WAIT_DONE :
                       (bus.iTxDone ? S_IDLE : S_WAIT_DONE);
        bus.oAck     = go ? grant : '0;
        bus.oTxStart = state == S_START;
        oBusy        = state != S_IDLE;
    end
    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) state <= S_IDLE;
        else        state <= stateNext;
    end
    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            ptr         <= '0;
            oOwner      <= '0;
            bus.oTxByte <= '0;
`ifdef UART_TX_ARB_LOCK_EN
            locked      <= 1'b0;
`endif
        end else if (go) begin
            ptr         <= IDX_W'(nextIdx(int'(winner), NREQ));
            oOwner      <= winner;
            bus.oTxByte <= bus.iData[{winner, 3'b000} +: 8];
`ifdef UART_TX_ARB_LOCK_EN
            locked      <= !bus.iLast[winner];
`endif
        end
    end
endmodule
